// File: rtl/cva6_clic_irq_gate_pkg.sv
// Shared types and constants for the registered CLIC interrupt gate.
// The latched struct carries an shv bit only when CVA6_CLIC_SHV_EN is defined.
package cva6_clic_irq_gate_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } gate_state_e;

    localparam int unsigned LEVEL_LSB    = 16;
    localparam int unsigned ID_MAX_WIDTH = 16;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0] id;
        logic [7:0]              level;
        logic [1:0]              priv;
`ifdef CVA6_CLIC_SHV_EN
        logic                    shv;
`endif
    } clic_irq_t;

    // Collapse target privileges that the hart does not implement onto M.
    function automatic logic [1:0] eff_priv(input int unsigned num_priv_modes,
                                            input logic [1:0]  priv);
        logic [1:0] res;
        res = priv;
        if (num_priv_modes == 1) begin
            res = PRIV_M;
        end else if (num_priv_modes == 2 && priv == PRIV_S) begin
            res = PRIV_M;
        end
        return res;
    endfunction

endpackage

// File: rtl/cva6_clic_eligibility.sv
// Combinational privilege/threshold check for one candidate interrupt.
module cva6_clic_eligibility
    import cva6_clic_irq_gate_pkg::*;
(
    input  logic [1:0] priv_lvl_i,
    input  logic       mie_i,
    input  logic       sie_i,
    input  logic [7:0] mth_i,
    input  logic [7:0] sth_i,
    input  logic [1:0] irq_priv_i,
    input  logic [7:0] irq_level_i,
    output logic       eligible_o
);

    always_comb begin
        eligible_o = 1'b0;
        case (priv_lvl_i)
            PRIV_M:  eligible_o = (irq_priv_i == PRIV_M) && (irq_level_i > mth_i) && mie_i;
            PRIV_S:  eligible_o = (irq_priv_i == PRIV_M) ||
                                  ((irq_priv_i == PRIV_S) && (irq_level_i > sth_i) && sie_i);
            PRIV_U:  eligible_o = 1'b1;
            default: eligible_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cva6_clic_irq_gate.sv
// Registered CLIC interrupt acceptance stage feeding the CVA6 ID stage.
// Optional selective-hardware-vectoring passthrough: define CVA6_CLIC_SHV_EN.
module cva6_clic_irq_gate
    import cva6_clic_irq_gate_pkg::*;
#(
    parameter  int unsigned NumSrc       = 256,
    parameter  int unsigned NumPrivModes = 3,
    parameter  int unsigned XLEN         = 64,
    localparam int unsigned IdWidth      = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         priv_lvl_i,
    input  logic               mie_i,
    input  logic               sie_i,
    input  logic [7:0]         mintthresh_i,
    input  logic [7:0]         sintthresh_i,
    input  logic [7:0]         mil_i,
    input  logic [7:0]         sil_i,
    input  logic               clic_irq_valid_i,
    input  logic [IdWidth-1:0] clic_irq_id_i,
    input  logic [7:0]         clic_irq_level_i,
    input  logic [1:0]         clic_irq_priv_i,
`ifdef CVA6_CLIC_SHV_EN
    input  logic               clic_irq_shv_i,
    output logic               irq_shv_o,
`endif
    output logic               clic_irq_ready_o,
    input  logic               clic_kill_req_i,
    output logic               clic_kill_ack_o,
    output logic               irq_req_o,
    output logic [XLEN-1:0]    irq_cause_o,
    input  logic               irq_taken_i
);

    gate_state_e state_q, state_d;
    clic_irq_t   irq_q, irq_d, irq_in;
    logic [7:0]  mth, sth;
    logic        elig_in, elig_q;
    logic        kill_ack;

    assign mth = (mintthresh_i > mil_i) ? mintthresh_i : mil_i;
    assign sth = (sintthresh_i > sil_i) ? sintthresh_i : sil_i;

    always_comb begin
        irq_in       = '0;
        irq_in.id    = ID_MAX_WIDTH'(clic_irq_id_i);
        irq_in.level = clic_irq_level_i;
        irq_in.priv  = eff_priv(NumPrivModes, clic_irq_priv_i);
`ifdef CVA6_CLIC_SHV_EN
        irq_in.shv   = clic_irq_shv_i;
`endif
    end

    cva6_clic_eligibility i_elig_in (
        .priv_lvl_i  (priv_lvl_i),
        .mie_i       (mie_i),
        .sie_i       (sie_i),
        .mth_i       (mth),
        .sth_i       (sth),
        .irq_priv_i  (irq_in.priv),
        .irq_level_i (irq_in.level),
        .eligible_o  (elig_in)
    );

    cva6_clic_eligibility i_elig_q (
        .priv_lvl_i  (priv_lvl_i),
        .mie_i       (mie_i),
        .sie_i       (sie_i),
        .mth_i       (mth),
        .sth_i       (sth),
        .irq_priv_i  (irq_q.priv),
        .irq_level_i (irq_q.level),
        .eligible_o  (elig_q)
    );

    // Taken outranks kill, which outranks withdrawal, which outranks preemption.
    always_comb begin
        state_d          = state_q;
        irq_d            = irq_q;
        clic_irq_ready_o = 1'b0;
        kill_ack         = 1'b0;
        case (state_q)
            IDLE: begin
                if (clic_kill_req_i) begin
                    kill_ack = 1'b1;
                end else if (clic_irq_valid_i && elig_in) begin
                    irq_d   = irq_in;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_taken_i) begin
                    clic_irq_ready_o = 1'b1;
                    state_d          = IDLE;
                end else if (clic_kill_req_i) begin
                    kill_ack = 1'b1;
                    state_d  = IDLE;
                end else if (!elig_q) begin
                    state_d = IDLE;
                end else if (clic_irq_valid_i && (irq_in.level > irq_q.level) && elig_in) begin
                    irq_d = irq_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also masks the combinational kill acknowledge.
    assign clic_kill_ack_o = kill_ack & rst_ni;
    assign irq_req_o       = (state_q == REQ);

    always_comb begin
        irq_cause_o = '0;
        if (state_q == REQ) begin
            irq_cause_o[XLEN-1]              = 1'b1;
            irq_cause_o[LEVEL_LSB +: 8]      = irq_q.level;
            irq_cause_o[ID_MAX_WIDTH-1:0]    = irq_q.id;
        end
    end

`ifdef CVA6_CLIC_SHV_EN
    assign irq_shv_o = (state_q == REQ) & irq_q.shv;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            irq_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_cva6_clic_irq_gate.sv
// Bench for cva6_clic_irq_gate: three instances (1, 2 and 3 privilege modes) share stimulus
// and are compared each cycle against a behavioural model; define CVA6_CLIC_SHV_EN to cover shv.
module tb_cva6_clic_irq_gate;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [1:0] priv_lvl;
    logic       mie, sie;
    logic [7:0] mintthresh, sintthresh, mil, sil;
    logic       valid;
    logic [7:0] id;
    logic [7:0] level;
    logic [1:0] ipriv;
    logic       kill;
    logic       taken;
    logic       shv;

    logic        irq_ready [1:3];
    logic        kill_ack  [1:3];
    logic        irq_req   [1:3];
    logic [63:0] irq_cause [1:3];
    logic        irq_shv   [1:3];

    int n_vec = 0;
    int n_err = 0;

    bit         m_req  [1:3];
    logic [7:0] m_id   [1:3];
    logic [7:0] m_lvl  [1:3];
    logic [1:0] m_priv [1:3];
    bit         m_shv  [1:3];

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        cva6_clic_irq_gate #(
            .NumSrc       (256),
            .NumPrivModes (g),
            .XLEN         (64)
        ) dut (
            .clk_i            (clk),
            .rst_ni           (rst_ni),
            .priv_lvl_i       (priv_lvl),
            .mie_i            (mie),
            .sie_i            (sie),
            .mintthresh_i     (mintthresh),
            .sintthresh_i     (sintthresh),
            .mil_i            (mil),
            .sil_i            (sil),
            .clic_irq_valid_i (valid),
            .clic_irq_id_i    (id),
            .clic_irq_level_i (level),
            .clic_irq_priv_i  (ipriv),
`ifdef CVA6_CLIC_SHV_EN
            .clic_irq_shv_i   (shv),
            .irq_shv_o        (irq_shv[g]),
`endif
            .clic_irq_ready_o (irq_ready[g]),
            .clic_kill_req_i  (kill),
            .clic_kill_ack_o  (kill_ack[g]),
            .irq_req_o        (irq_req[g]),
            .irq_cause_o      (irq_cause[g]),
            .irq_taken_i      (taken)
        );
`ifndef CVA6_CLIC_SHV_EN
        assign irq_shv[g] = 1'b0;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [1:0] model_priv(input int modes, input logic [1:0] p);
        if (modes == 1) return 2'b11;
        if (modes == 2 && p == 2'b01) return 2'b11;
        return p;
    endfunction

    function automatic bit model_elig(input logic [1:0] p, input logic [7:0] lvl);
        logic [7:0] mt, st;
        mt = max8(mintthresh, mil);
        st = max8(sintthresh, sil);
        if (priv_lvl == 2'b11) return (p == 2'b11) && (lvl > mt) && mie;
        if (priv_lvl == 2'b01) return (p == 2'b11) || ((p == 2'b01) && (lvl > st) && sie);
        if (priv_lvl == 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_cause(input logic [7:0] lvl, input logic [7:0] i);
        return 64'h8000_0000_0000_0000 | (64'(lvl) << 16) | 64'(i);
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 3; k++) begin
            m_req[k] = 0; m_id[k] = '0; m_lvl[k] = '0; m_priv[k] = '0; m_shv[k] = 0;
        end
    endtask

    // Compare every instance mid-cycle, then advance the model to the next edge.
    task automatic step();
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            logic [1:0] ep;
            bit         in_ok;
            ep    = model_priv(k, ipriv);
            in_ok = valid && model_elig(ep, level);
            chk($sformatf("m%0d_req", k), irq_req[k], m_req[k]);
            chk($sformatf("m%0d_cause", k), irq_cause[k], m_req[k] ? model_cause(m_lvl[k], m_id[k]) : 64'd0);
            chk($sformatf("m%0d_ready", k), irq_ready[k], m_req[k] && taken);
            chk($sformatf("m%0d_ack", k), kill_ack[k], kill && !(m_req[k] && taken));
`ifdef CVA6_CLIC_SHV_EN
            chk($sformatf("m%0d_shv", k), irq_shv[k], m_req[k] && m_shv[k]);
`endif
            if (!m_req[k]) begin
                if (!kill && in_ok) begin
                    m_req[k] = 1; m_id[k] = id; m_lvl[k] = level; m_priv[k] = ep; m_shv[k] = shv;
                end
            end else if (taken || kill || !model_elig(m_priv[k], m_lvl[k])) begin
                m_req[k] = 0;
            end else if (in_ok && level > m_lvl[k]) begin
                m_id[k] = id; m_lvl[k] = level; m_priv[k] = ep; m_shv[k] = shv;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] i, input logic [7:0] l, input logic [1:0] p);
        valid = 1'b1; id = i; level = l; ipriv = p;
        step();
        valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; priv_lvl = 2'b11; mie = 1'b1; sie = 1'b1;
        mintthresh = 8'h40; sintthresh = 8'h00; mil = 8'h00; sil = 8'h00;
        valid = 1'b0; id = '0; level = '0; ipriv = 2'b11; kill = 1'b0; taken = 1'b0; shv = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", irq_req[3], 0);
        chk("rst_cause", irq_cause[3], 0);
        chk("rst_ready", irq_ready[3], 0);
        chk("rst_ack", kill_ack[3], 0);
        rst_ni = 1'b1;
        step();

        // M-mode acceptance, then preemption by a higher level, then take
        shv = 1'b1;
        present(8'd5, 8'h41, 2'b11);
        shv = 1'b0;
        chk("acc_req", irq_req[3], 1);
        chk("acc_cause", irq_cause[3], 64'h8000_0000_0041_0005);
        present(8'd9, 8'h80, 2'b11);
        chk("pre_cause", irq_cause[3], 64'h8000_0000_0080_0009);
        taken = 1'b1;
        #1 chk("take_ready", irq_ready[3], 1);
        step();
        taken = 1'b0;
        #1 chk("take_req_low", irq_req[3], 0);

        // Threshold raised while requesting: withdraw without ready
        present(8'd5, 8'h41, 2'b11);
        chk("thr_req", irq_req[3], 1);
        mintthresh = 8'h50;
        #1 chk("thr_ready", irq_ready[3], 0);
        step();
        chk("thr_withdraw", irq_req[3], 0);
        mintthresh = 8'h40;

        // Kill in REQ, and kill coincident with take
        present(8'd7, 8'h60, 2'b11);
        kill = 1'b1;
        #1 chk("kill_ack", kill_ack[3], 1);
        step();
        kill = 1'b0;
        chk("kill_req_low", irq_req[3], 0);
        present(8'd7, 8'h60, 2'b11);
        kill = 1'b1; taken = 1'b1;
        #1 chk("kt_ready", irq_ready[3], 1);
        chk("kt_no_ack", kill_ack[3], 0);
        step();
        taken = 1'b0;
        #1 chk("kt_late_ack", kill_ack[3], 1);
        step();
        kill = 1'b0;

        // U mode accepts an S irq; two-mode build treats it as M once the hart is in M
        priv_lvl = 2'b00; mintthresh = 8'h10;
        present(8'd3, 8'h30, 2'b01);
        chk("u_req2", irq_req[2], 1);
        priv_lvl = 2'b11;
        step();
        chk("u_m_keep2", irq_req[2], 1);
        chk("u_m_drop3", irq_req[3], 0);
        taken = 1'b1; step(); taken = 1'b0;

        // S mode with sie clear: only builds that fold S onto M accept an S irq
        priv_lvl = 2'b01; sie = 1'b0;
        present(8'd4, 8'h30, 2'b01);
        chk("s_req1", irq_req[1], 1);
        chk("s_req3", irq_req[3], 0);
        taken = 1'b1; step(); taken = 1'b0;
        sie = 1'b1; priv_lvl = 2'b11;

        // Asynchronous reset while requesting
        present(8'd8, 8'h70, 2'b11);
        chk("ar_pre", irq_req[3], 1);
        taken = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_req", irq_req[3], 0);
        chk("ar_cause", irq_cause[3], 0);
        chk("ar_ready", irq_ready[3], 0);
        chk("ar_shv", irq_shv[3], 0);
        @(posedge clk);
        #1;
        model_reset();
        taken = 1'b0; rst_ni = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 2))
                0: priv_lvl = 2'b00;
                1: priv_lvl = 2'b01;
                default: priv_lvl = 2'b11;
            endcase
            if ($urandom_range(0, 7) == 0) priv_lvl = 2'b10;
            mie        = ($urandom_range(0, 7) != 0);
            sie        = ($urandom_range(0, 7) != 0);
            mintthresh = 8'($urandom_range(0, 160));
            sintthresh = 8'($urandom_range(0, 160));
            mil        = 8'($urandom_range(0, 100));
            sil        = 8'($urandom_range(0, 100));
            valid      = ($urandom_range(0, 9) < 6);
            id         = 8'($urandom);
            level      = 8'($urandom);
            ipriv      = 2'($urandom);
            shv        = 1'($urandom);
            kill       = ($urandom_range(0, 9) == 0);
            taken      = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cva6_clic_irq_gate.md
# cva6_clic_irq_gate

Registered CLIC interrupt acceptance stage between the CLIC and the CVA6 ID stage. It supersedes the combinational CLIC controller. It latches the winning CLIC interrupt and holds it as a stable request to the pipeline. It handles preemption by higher-level interrupts, withdrawal when the interrupt becomes ineligible, and kill requests through an explicit state machine. It supports 1, 2 or 3 implemented privilege modes.

## Interface
Parameters:
- NumSrc, 256: number of CLIC interrupt sources; IdWidth = $clog2(NumSrc), IdWidth ≤ 16.
- NumPrivModes, 3: 1 = M only, 2 = M+U, 3 = M+S+U.
- XLEN, 64: cause width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- priv_lvl_i  in  2  current hart privilege level.
- mie_i, sie_i  in  1 each  global interrupt enables from mstatus.
- mintthresh_i, sintthresh_i  in  8 each  interrupt thresholds.
- mil_i, sil_i  in  8 each  current M/S interrupt level from mintstatus.
- clic_irq_valid_i  in  1  CLIC presents an interrupt.
- clic_irq_id_i  in  IdWidth  interrupt ID.
- clic_irq_level_i  in  8  interrupt level.
- clic_irq_priv_i  in  2  interrupt target privilege.
- clic_irq_ready_o  out  1  one-cycle pulse: latched interrupt taken by the hart.
- clic_kill_req_i  in  1  CLIC revokes the presented interrupt.
- clic_kill_ack_o  out  1  kill acknowledged.
- irq_req_o  out  1  interrupt request to ID stage.
- irq_cause_o  out  XLEN  packed cause.
- irq_taken_i  in  1  ID stage consumes the request this cycle.

## Operation
- Effective priv: NumPrivModes=1 maps every clic_irq_priv_i to M. NumPrivModes=2 maps S to M.
- Thresholds: mth = max(mintthresh_i, mil_i); sth = max(sintthresh_i, sil_i).
- eligible(priv, level):
  - In M mode: priv==M && level>mth && mie_i.
  - In S mode: priv==M, or (priv==S && level>sth && sie_i).
  - In U mode: always true.
- Eligibility is evaluated on the latched values in REQ and on the inputs in IDLE.
- FSM states: IDLE, REQ.
- IDLE:
  - If clic_kill_req_i: clic_kill_ack_o=1 and nothing is latched.
  - Otherwise, if clic_irq_valid_i && eligible(inputs): latch id/level/priv and go to REQ.
- REQ (checks in priority order):
  - irq_taken_i: pulse clic_irq_ready_o, go to IDLE.
  - Else clic_kill_req_i: clic_kill_ack_o=1, go to IDLE (withdraw).
  - Else latched value no longer eligible (threshold, enable or priv changed): go to IDLE (withdraw).
  - Else clic_irq_valid_i && input level > latched level && eligible(inputs): relatch (preempt) and stay in REQ.
- Taken and kill in the same cycle: taken wins and no ack is given. The kill is acked in IDLE on the next cycle if still asserted.
- irq_req_o = (state==REQ).
- irq_cause_o = {1'b1, zeros[XLEN-2:24], level_q[7:0] at [23:16], zeros, id_q at [IdWidth-1:0]}.
- irq_cause_o is 0 in IDLE.

## Timing
- Reset: state IDLE. All outputs 0. Latches 0.
- Latency from clic_irq_valid_i to irq_req_o: 1 cycle.
- Latency from irq_taken_i to clic_irq_ready_o: 0 cycles (same cycle). irq_req_o is low on the next cycle.
- clic_kill_ack_o is combinational in the same cycle as clic_kill_req_i when acked.
- irq_cause_o is stable while irq_req_o is high, except on the cycle following a preempt relatch.
- The ID stage must sample irq_cause_o in the cycle irq_taken_i is asserted.
- Back-to-back: a new request can be latched no earlier than the cycle after a take.

## Configuration
- CVA6_CLIC_SHV_EN defined:
  - Adds input clic_irq_shv_i (1) and output irq_shv_o (1).
  - shv is latched with id; irq_shv_o = shv_q in REQ, 0 otherwise; reset 0.
- Undefined: the ports are absent and no shv state exists.

## Structure
- Shared package: the FSM state enum, cause field offsets (LEVEL_LSB=16, ID_MAX_WIDTH=16), and the latched-interrupt struct (id, level, priv, shv).
- One sub-module, cva6_clic_eligibility: a purely combinational priv/threshold check. It is instantiated twice, once for the inputs and once for the latched values.

## Test plan
- M mode, mie=1, mth=0x40; valid id=5 level=0x41 priv=M -> irq_req_o=1 the next cycle; cause = 0x8000_0000_0041_0005.
- In REQ with id=5 level=0x41: valid id=9 level=0x80 -> cause becomes 0x…0080_0009 the next cycle. Then irq_taken_i -> clic_irq_ready_o pulses the same cycle.
- In REQ: mintthresh raised to 0x50 -> irq_req_o drops the next cycle; clic_irq_ready_o stays 0.
- kill_req asserted in REQ -> kill_ack the same cycle, irq_req_o=0 the next cycle. kill_req together with irq_taken_i -> ready pulse, ack one cycle later.
- NumPrivModes=2, U mode: priv=S irq -> accepted as M. NumPrivModes=1: S-mode inputs never gate on sie_i.
- rst_ni asserted mid-REQ -> all outputs 0 asynchronously. With CVA6_CLIC_SHV_EN defined, irq_shv_o follows the latched shv.
